// File: rtl/ysyx_23060061_mem_arbiter.sv
// ysyx_23060061_mem_arbiter
// Two-requester memory arbiter. The instruction fetch unit (IFU) and the
// load/store unit (LSU) share one memory port. Only one transaction is in
// flight at a time. When both units ask in the same cycle, round-robin
// arbitration picks the unit that was not served last.
//
// Ports
//   clk, rst                        clock; synchronous active-high reset
//   ifu_req_valid/ready, ifu_addr   IFU fetch request handshake
//   ifu_rsp_valid                   IFU response pulse
//   lsu_req_valid/ready, lsu_addr,
//   lsu_wen, lsu_wdata, lsu_wmask   LSU load/store request handshake
//   lsu_rsp_valid                   LSU load data / store acknowledge pulse
//   mem_req_valid/ready, mem_addr,
//   mem_wen, mem_wdata, mem_wmask   memory-side request
//   mem_rsp_valid, mem_rdata        memory-side response
//   rsp_rdata, rsp_err              shared response payload, qualified by
//                                   ifu_rsp_valid or lsu_rsp_valid
//
// Configuration
//   YSYX_23060061_MEM_ARB_TIMEOUT_EN  When defined, a watchdog is enabled.
//                                     If memory stays silent for TIMEOUT
//                                     cycles in RSP, the arbiter answers the
//                                     owner with rsp_err=1 and rsp_rdata=0.
module ysyx_23060061_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_rsp_valid,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_rsp_valid,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    state_t              state_q, state_d;
    logic                lastLsu_q, lastLsu_d;
    logic                ownerLsu_q, ownerLsu_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wmask_q, wmask_d;
    logic                grantIfu;
    logic                grantLsu;
    logic                rspErr;

`ifdef YSYX_23060061_MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // IFU wins a tie only when the LSU was served last. A lone requester
    // always wins.
    assign grantIfu = ifu_req_valid && (!lsu_req_valid || lastLsu_q);
    assign grantLsu = lsu_req_valid && !grantIfu;

    // The memory request mirrors the registered transaction. During reset,
    // every handshake output is forced low.
    assign mem_req_valid = !rst && (state_q == REQ);
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;

`ifdef YSYX_23060061_MEM_ARB_TIMEOUT_EN
    assign rsp_err = rspErr;
`else
    assign rsp_err = 1'b0;
`endif

    // Next-state and output decode. Readiness and response pulses are
    // combinational, so a grant or response lands in the same cycle.
    always_comb begin
        state_d       = state_q;
        lastLsu_d     = lastLsu_q;
        ownerLsu_d    = ownerLsu_q;
        addr_d        = addr_q;
        wen_d         = wen_q;
        wdata_d       = wdata_q;
        wmask_d       = wmask_q;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        lsu_rsp_valid = 1'b0;
        rsp_rdata     = '0;
        rspErr        = 1'b0;
`ifdef YSYX_23060061_MEM_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
`endif
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (grantIfu) begin
                        ifu_req_ready = 1'b1;
                        ownerLsu_d    = 1'b0;
                        lastLsu_d     = 1'b0;
                        addr_d        = ifu_addr;
                        wen_d         = 1'b0;
                        wdata_d       = '0;
                        wmask_d       = '0;
                        state_d       = REQ;
                    end else if (grantLsu) begin
                        lsu_req_ready = 1'b1;
                        ownerLsu_d    = 1'b1;
                        lastLsu_d     = 1'b1;
                        addr_d        = lsu_addr;
                        wen_d         = lsu_wen;
                        wdata_d       = lsu_wdata;
                        wmask_d       = lsu_wmask;
                        state_d       = REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        state_d = RSP;
`ifdef YSYX_23060061_MEM_ARB_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
                RSP: begin
                    if (mem_rsp_valid) begin
                        ifu_rsp_valid = !ownerLsu_q;
                        lsu_rsp_valid = ownerLsu_q;
                        rsp_rdata     = mem_rdata;
                        state_d       = IDLE;
`ifdef YSYX_23060061_MEM_ARB_TIMEOUT_EN
                    end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                        ifu_rsp_valid = !ownerLsu_q;
                        lsu_rsp_valid = ownerLsu_q;
                        rspErr        = 1'b1;
                        state_d       = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register. Reset drops any in-flight transaction. It also marks
    // the LSU as last served, so the IFU wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lastLsu_q  <= 1'b1;
            ownerLsu_q <= 1'b0;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
`ifdef YSYX_23060061_MEM_ARB_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            lastLsu_q  <= lastLsu_d;
            ownerLsu_q <= ownerLsu_d;
            addr_q     <= addr_d;
            wen_q      <= wen_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
`ifdef YSYX_23060061_MEM_ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_ysyx_23060061_mem_arbiter.sv
// Testbench for ysyx_23060061_mem_arbiter.
// A transaction-level model tracks whether a request is outstanding, whether
// memory has taken it, who owns it and how long the response has been
// pending. From this, every output is predicted on every falling edge.
// Directed scenarios add literal expectations at key cycles.
module tb_ysyx_23060061_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
   logic [AW-1:0] ifu_addr;
   logic          lsu_req_valid, lsu_req_ready, lsu_rsp_valid, lsu_wen;
   logic [AW-1:0] lsu_addr;
   logic [DW-1:0] lsu_wdata;
   logic [3:0]    lsu_wmask;
   logic          mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata, rsp_rdata;
   logic [3:0]    mem_wmask;
   logic          rsp_err;

   int total = 0;
   int bad = 0;
   bit modelOn = 1'b0;

   // Model state: one outstanding transaction at most
   bit            mOut;
   bit            mIssued;
   bit            mOwnerLsu;
   bit            mLastLsu;
   int            mTimer;
   logic [AW-1:0] mAddr;
   logic          mWen;
   logic [DW-1:0] mWdata;
   logic [3:0]    mWmask;

   ysyx_23060061_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
      .ifu_addr(ifu_addr), .ifu_rsp_valid(ifu_rsp_valid),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
      .lsu_addr(lsu_addr), .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata),
      .lsu_wmask(lsu_wmask), .lsu_rsp_valid(lsu_rsp_valid),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid),
      .mem_rdata(mem_rdata), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   // 10-time-unit clock
   always #5 clk = ~clk;

   // Global safety net so the run can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Round-robin rule: a lone requester wins; on a tie, the unit not served last wins
   function automatic bit pickLsu(input bit ifuV, input bit lsuV, input bit lastLsu);
      if (ifuV && lsuV) return !lastLsu;
      return lsuV;
   endfunction

   function automatic bit timedOut(input int timer);
`ifdef YSYX_23060061_MEM_ARB_TIMEOUT_EN
      return timer == TO;
`else
      return 1'b0;
`endif
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input bit ifuV, input logic [AW-1:0] ifuA,
                                input bit lsuV, input logic [AW-1:0] lsuA,
                                input bit wen, input logic [DW-1:0] wdata,
                                input logic [3:0] wmask, input bit memReady,
                                input bit memRspV, input logic [DW-1:0] memRdata);
      ifu_req_valid = ifuV;
      ifu_addr      = ifuA;
      lsu_req_valid = lsuV;
      lsu_addr      = lsuA;
      lsu_wen       = wen;
      lsu_wdata     = wdata;
      lsu_wmask     = wmask;
      mem_req_ready = memReady;
      mem_rsp_valid = memRspV;
      mem_rdata     = memRdata;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs();
      applyStimulus(0, '0, 0, '0, 0, '0, '0, 0, 0, '0);
   endtask

   // Model update at each rising edge, using the inputs stable around it
   always @(posedge clk) begin
      if (rst) begin
         mOut     = 1'b0;
         mIssued  = 1'b0;
         mLastLsu = 1'b1;
         mTimer   = 0;
      end else if (!mOut) begin
         if (ifu_req_valid || lsu_req_valid) begin
            mOut      = 1'b1;
            mIssued   = 1'b0;
            mOwnerLsu = pickLsu(ifu_req_valid, lsu_req_valid, mLastLsu);
            mLastLsu  = mOwnerLsu;
            mAddr     = mOwnerLsu ? lsu_addr : ifu_addr;
            mWen      = mOwnerLsu ? lsu_wen : 1'b0;
            mWdata    = mOwnerLsu ? lsu_wdata : '0;
            mWmask    = mOwnerLsu ? lsu_wmask : '0;
         end
      end else if (!mIssued) begin
         if (mem_req_ready) begin
            mIssued = 1'b1;
            mTimer  = 0;
         end
      end else begin
         if (mem_rsp_valid || timedOut(mTimer)) mOut = 1'b0;
         else mTimer++;
      end
   end

   // Compare every output against the model on each falling edge
   always @(negedge clk) begin : compareProc
      bit anyReq, eLsu, eMemV, eRspReal, eRspTo;
      if (modelOn) begin
         anyReq   = !rst && !mOut && (ifu_req_valid || lsu_req_valid);
         eLsu     = pickLsu(ifu_req_valid, lsu_req_valid, mLastLsu);
         eMemV    = !rst && mOut && !mIssued;
         eRspReal = !rst && mOut && mIssued && mem_rsp_valid;
         eRspTo   = !rst && mOut && mIssued && !mem_rsp_valid && timedOut(mTimer);
         checkOutput("m_ifu_req_ready", ifu_req_ready, anyReq && !eLsu);
         checkOutput("m_lsu_req_ready", lsu_req_ready, anyReq && eLsu);
         checkOutput("m_mem_req_valid", mem_req_valid, eMemV);
         if (eMemV) begin
            checkOutput("m_mem_addr", mem_addr, mAddr);
            checkOutput("m_mem_wen", mem_wen, mWen);
            checkOutput("m_mem_wdata", mem_wdata, mWdata);
            checkOutput("m_mem_wmask", mem_wmask, mWmask);
         end
         checkOutput("m_ifu_rsp_valid", ifu_rsp_valid, (eRspReal || eRspTo) && !mOwnerLsu);
         checkOutput("m_lsu_rsp_valid", lsu_rsp_valid, (eRspReal || eRspTo) && mOwnerLsu);
         checkOutput("m_rsp_rdata", rsp_rdata, eRspReal ? mem_rdata : '0);
         checkOutput("m_rsp_err", rsp_err, eRspTo);
      end
   end

   initial begin : stim
      bit gotLsu, ok;
      rst = 1'b1;
      idleInputs();
      tick();
      modelOn = 1'b1;
      tick();
      @(negedge clk);
      checkOutput("rst_ifu_req_ready", ifu_req_ready, 0);
      checkOutput("rst_mem_req_valid", mem_req_valid, 0);
      checkOutput("rst_mem_addr", mem_addr, 0);
      checkOutput("rst_rsp_rdata", rsp_rdata, 0);
      checkOutput("rst_ifu_rsp_valid", ifu_rsp_valid, 0);
      tick();
      rst = 1'b0;

      // IFU-only fetch, memory accepts at once and answers two cycles after acceptance
      applyStimulus(1, 32'h8000_0000, 0, '0, 0, '0, '0, 1, 0, '0);
      @(negedge clk);
      checkOutput("s1_ifu_req_ready", ifu_req_ready, 1);
      tick();
      applyStimulus(0, '0, 0, '0, 0, '0, '0, 1, 0, '0);
      @(negedge clk);
      checkOutput("s1_mem_req_valid", mem_req_valid, 1);
      checkOutput("s1_mem_addr", mem_addr, 64'h8000_0000);
      checkOutput("s1_mem_wen", mem_wen, 0);
      tick();
      applyStimulus(0, '0, 0, '0, 0, '0, '0, 1, 1, 32'h0010_0073);
      @(negedge clk);
      checkOutput("s1_ifu_rsp_valid", ifu_rsp_valid, 1);
      checkOutput("s1_rsp_rdata", rsp_rdata, 64'h0010_0073);
      checkOutput("s1_lsu_rsp_valid", lsu_rsp_valid, 0);
      tick();
      idleInputs();
      @(negedge clk);
      checkOutput("s1_ifu_rsp_after", ifu_rsp_valid, 0);
      checkOutput("s1_mem_req_after", mem_req_valid, 0);
      tick();

      // Both units valid after reset: grants alternate IFU, LSU, IFU, LSU
      rst = 1'b1;
      tick();
      rst = 1'b0;
      applyStimulus(1, 32'h8000_0100, 1, 32'h8000_0200, 0, 32'h0, 4'h0, 1, 1, 32'h1122_3344);
      for (int i = 0; i < 4; i++) begin
         ok = 1'b0;
         gotLsu = 1'b0;
         for (int c = 0; c < 10 && !ok; c++) begin
            @(negedge clk);
            if (ifu_req_ready || lsu_req_ready) begin
               ok = 1'b1;
               gotLsu = lsu_req_ready;
            end
         end
         checkOutput($sformatf("s2_grant_seen_%0d", i), ok, 1);
         checkOutput($sformatf("s2_grant_lsu_%0d", i), gotLsu, (i % 2) == 1);
         tick();
      end
      applyStimulus(0, '0, 0, '0, 0, '0, '0, 1, 1, 32'h1122_3344);
      repeat (3) tick();
      idleInputs();
      tick();

      // LSU store with memory stalling three cycles; fields must hold for all four REQ cycles
      applyStimulus(0, '0, 1, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'hF, 0, 0, '0);
      @(negedge clk);
      checkOutput("s3_lsu_req_ready", lsu_req_ready, 1);
      checkOutput("s3_ifu_req_ready", ifu_req_ready, 0);
      tick();
      for (int k = 0; k < 4; k++) begin
         applyStimulus(0, '0, 0, 32'h1234_5678, 0, 32'h0, 4'h0, k == 3, 0, '0);
         @(negedge clk);
         checkOutput($sformatf("s3_mem_req_valid_%0d", k), mem_req_valid, 1);
         checkOutput($sformatf("s3_mem_addr_%0d", k), mem_addr, 64'h8000_1000);
         checkOutput($sformatf("s3_mem_wen_%0d", k), mem_wen, 1);
         checkOutput($sformatf("s3_mem_wdata_%0d", k), mem_wdata, 64'hDEAD_BEEF);
         checkOutput($sformatf("s3_mem_wmask_%0d", k), mem_wmask, 64'hF);
         tick();
      end
      applyStimulus(0, '0, 0, '0, 0, '0, '0, 0, 1, 32'h0000_0055);
      @(negedge clk);
      checkOutput("s3_lsu_rsp_valid", lsu_rsp_valid, 1);
      checkOutput("s3_ifu_rsp_valid", ifu_rsp_valid, 0);
      checkOutput("s3_mem_req_valid_rsp", mem_req_valid, 0);
      tick();
      idleInputs();
      tick();

      // Memory response while idle is ignored, and the arbiter still grants at once
      applyStimulus(0, '0, 0, '0, 0, '0, '0, 0, 1, 32'hCAFE_F00D);
      @(negedge clk);
      checkOutput("s6_ifu_rsp_valid", ifu_rsp_valid, 0);
      checkOutput("s6_lsu_rsp_valid", lsu_rsp_valid, 0);
      checkOutput("s6_rsp_rdata", rsp_rdata, 0);
      tick();
      applyStimulus(1, 32'h8000_0400, 0, '0, 0, '0, '0, 1, 0, '0);
      @(negedge clk);
      checkOutput("s6_mem_req_valid", mem_req_valid, 0);
      checkOutput("s6_ifu_req_ready", ifu_req_ready, 1);
      tick();
      applyStimulus(0, '0, 0, '0, 0, '0, '0, 1, 0, '0);
      tick();
      applyStimulus(0, '0, 0, '0, 0, '0, '0, 1, 1, 32'h0000_0013);
      tick();
      idleInputs();
      tick();

      // Reset while in RSP drops the transaction; a later memory response is ignored
      applyStimulus(1, 32'h8000_2000, 0, '0, 0, '0, '0, 1, 0, '0);
      tick();
      applyStimulus(0, '0, 0, '0, 0, '0, '0, 1, 0, '0);
      tick();
      rst = 1'b1;
      idleInputs();
      @(negedge clk);
      checkOutput("s4_ifu_rsp_in_rst", ifu_rsp_valid, 0);
      tick();
      rst = 1'b0;
      applyStimulus(0, '0, 0, '0, 0, '0, '0, 0, 1, 32'h0000_ABCD);
      @(negedge clk);
      checkOutput("s4_ifu_rsp_valid", ifu_rsp_valid, 0);
      checkOutput("s4_lsu_rsp_valid", lsu_rsp_valid, 0);
      checkOutput("s4_rsp_rdata", rsp_rdata, 0);
      checkOutput("s4_mem_req_valid", mem_req_valid, 0);
      checkOutput("s4_mem_addr", mem_addr, 0);
      checkOutput("s4_rsp_err", rsp_err, 0);
      tick();
      idleInputs();
      tick();

      // Silent memory: timeout build answers with an error, default build keeps waiting
      applyStimulus(1, 32'h8000_3000, 0, '0, 0, '0, '0, 1, 0, '0);
      tick();
      applyStimulus(0, '0, 0, '0, 0, '0, '0, 1, 0, '0);
      tick();
`ifdef YSYX_23060061_MEM_ARB_TIMEOUT_EN
      for (int k = 0; k < TO; k++) begin
         @(negedge clk);
         checkOutput($sformatf("s5_no_rsp_%0d", k), ifu_rsp_valid, 0);
         tick();
      end
      @(negedge clk);
      checkOutput("s5_to_ifu_rsp_valid", ifu_rsp_valid, 1);
      checkOutput("s5_to_rsp_err", rsp_err, 1);
      checkOutput("s5_to_rsp_rdata", rsp_rdata, 0);
      tick();
      @(negedge clk);
      checkOutput("s5_to_after", ifu_rsp_valid, 0);
`else
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         checkOutput($sformatf("s5_no_rsp_%0d", k), ifu_rsp_valid, 0);
         tick();
      end
      applyStimulus(0, '0, 0, '0, 0, '0, '0, 0, 1, 32'h0000_7777);
      @(negedge clk);
      checkOutput("s5_late_ifu_rsp_valid", ifu_rsp_valid, 1);
      checkOutput("s5_late_rsp_rdata", rsp_rdata, 64'h7777);
      checkOutput("s5_late_rsp_err", rsp_err, 0);
`endif
      tick();
      idleInputs();
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
